// File: rtl/vc_router_pkg.sv
// Shared types and helpers for the response router.
// Default payload type and counter width helper.
package vc_router_pkg;

  localparam int PLD_W = 8;

  typedef logic [PLD_W-1:0] pld_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/router_dst_fifo.sv
// Per-destination FIFO: dual ordered write, single read.
// Count is registered; head is the oldest entry.
module router_dst_fifo
  import vc_router_pkg::*;
#(
  parameter int PLD_WIDTH = 8,
  parameter int DEPTH     = 2,
  localparam int CW       = cnt_w(DEPTH),
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr0_en,
  input  logic [PLD_WIDTH-1:0] wr0_pld,
  input  logic                 wr1_en,
  input  logic [PLD_WIDTH-1:0] wr1_pld,
  input  logic                 rd_rdy,
  output logic [CW-1:0]        cnt,
  output logic [PLD_WIDTH-1:0] head
);

  logic [PLD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [PW-1:0]        wptr1;
  logic [PW-1:0]        wptr2;
  logic                 pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wptr1 = inc(wptr);
  assign wptr2 = inc(wptr1);
  assign pop   = rd_rdy & (cnt != '0);
  assign head  = mem[rptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr0_en) mem[wptr] <= wr0_pld;
      if (wr1_en) mem[wr0_en ? wptr1 : wptr] <= wr1_pld;
      if (wr0_en & wr1_en)      wptr <= wptr2;
      else if (wr0_en | wr1_en) wptr <= wptr1;
      if (pop) rptr <= inc(rptr);
      cnt <= cnt + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
    end
  end

endmodule

// File: rtl/two_to_n_resp_router.sv
// Two-lane to N-destination response router with per-destination FIFOs.
// Option: TWO_TO_N_ROUTER_DST_CHK_EN drops out-of-range lanes and flags err_vld.
module two_to_n_resp_router
  import vc_router_pkg::*;
#(
  parameter int N          = 10,
  parameter int PLD_WIDTH  = 8,
  parameter int DEPTH      = 2,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     in_vld,
  output logic [1:0]                     in_rdy,
  input  logic [1:0][IDX_W-1:0]          in_dst,
  input  logic [1:0][PLD_WIDTH-1:0]      in_pld,
  output logic [N-1:0]                   out_vld,
  input  logic [N-1:0]                   out_rdy,
  output logic [N-1:0][PLD_WIDTH-1:0]    out_pld,
  output logic                           err_vld
);

  localparam int NP = 1 << IDX_W;
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0] cnt [N];
  logic [NP-1:0] sp1;
  logic [NP-1:0] sp2;
  logic [1:0]    bad;
  logic [1:0]    act;
  logic [1:0]    push;
  logic [1:0]    rdy;
  logic          same;
  logic          conflict;
  logic          prio;

  for (genvar d = 0; d < N; d++) begin : g_dst
    router_dst_fifo #(
      .PLD_WIDTH (PLD_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr0_en  (push[0] & (in_dst[0] == IDX_W'(d))),
      .wr0_pld (in_pld[0]),
      .wr1_en  (push[1] & (in_dst[1] == IDX_W'(d))),
      .wr1_pld (in_pld[1]),
      .rd_rdy  (out_rdy[d]),
      .cnt     (cnt[d]),
      .head    (out_pld[d])
    );
    assign sp1[d]     = cnt[d] < CW'(DEPTH);
    assign sp2[d]     = cnt[d] <= CW'(DEPTH - 2);
    assign out_vld[d] = cnt[d] != '0;
  end

  for (genvar d = N; d < NP; d++) begin : g_pad
    assign sp1[d] = 1'b0;
    assign sp2[d] = 1'b0;
  end

`ifdef TWO_TO_N_ROUTER_DST_CHK_EN
  for (genvar i = 0; i < 2; i++) begin : g_chk
    assign bad[i] = in_vld[i] &
                    ({1'b0, in_dst[i]} >= (IDX_W + 1)'(N));
  end
`else
  assign bad = 2'b00;
`endif

  assign act  = in_vld & ~bad;
  assign same = act[0] & act[1] & (in_dst[0] == in_dst[1]);

  // lane readiness from registered occupancy and prio only
  always_comb begin
    rdy      = {sp1[in_dst[1]], sp1[in_dst[0]]};
    conflict = 1'b0;
    if (same) begin
      if (sp2[in_dst[0]]) begin
        rdy = 2'b11;
      end else if (sp1[in_dst[0]]) begin
        rdy      = prio ? 2'b10 : 2'b01;
        conflict = 1'b1;
      end else begin
        rdy = 2'b00;
      end
    end
  end

  assign in_rdy = rdy | bad;
  assign push   = act & rdy;

  // winner of a one-slot conflict always transfers, so flip on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= 1'b0;
    else if (conflict) prio <= ~prio;
  end

`ifdef TWO_TO_N_ROUTER_DST_CHK_EN
  logic err_q;

  // sticky out-of-range flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (|bad) err_q <= 1'b1;
  end

  assign err_vld = err_q;
`else
  assign err_vld = 1'b0;
`endif

endmodule
